// File: rtl/i2c_target_regport.sv
// I2C target bridging the bus to a byte-wide register port with pointer auto-increment.
// Latency: pin edge to FSM action SYNC_STAGES+FILTER_LEN+1 clk; reg_re/shifter load 1 clk after scl fall.
// Backpressure: none; no clock stretching, reg_rdata must be valid combinationally while reg_re is high.
module i2c_target_regport #(
  parameter logic [6:0] I2C_ADDR    = 7'h70,
  parameter int         NUM_REGS    = 12,
  parameter int         PTR_W       = 4,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3,
  parameter int         WRAP        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_out,
  output logic             sda_oe,
  output logic             reg_we,
  output logic [PTR_W-1:0] reg_waddr,
  output logic [7:0]       reg_wdata,
  output logic             reg_re,
  output logic [PTR_W-1:0] reg_raddr,
  input  logic [7:0]       reg_rdata,
  output logic             busy
);

  localparam int               CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  // index 0 = scl, index 1 = sda
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [1:0]             raw, filt, filt_d;
  logic [CNT_W-1:0]       cnt [2];

  state_t           state, state_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n, byte_in, rd_byte;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc, waddr_n;
  logic [7:0]       wdata_n;
  logic             past_end, past_end_n, past_inc;
  logic             sda_oe_n, busy_n, we_n, ld, ld_n, rw, rw_n;
  logic             scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;

  assign sda_out   = 1'b0;
  assign reg_raddr = ptr;
  assign reg_re    = ld & ~past_end;
  assign rd_byte   = past_end ? 8'hFF : reg_rdata;

  // input synchronisers
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign raw = {sda_sync[SYNC_STAGES-1], scl_sync[SYNC_STAGES-1]};

  // glitch filter: a new level is accepted only after FILTER_LEN consecutive equal samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filt   <= '1;
      filt_d <= '1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
          filt[i] <= raw[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise = filt[0] & ~filt_d[0];
  assign scl_fall = ~filt[0] & filt_d[0];
  assign start_c  = ~filt[1] & filt_d[1] & scl_f;
  assign stop_c   = filt[1] & ~filt_d[1] & scl_f;
  assign byte_in  = {shreg[6:0], sda_f};

  // pointer increment: wrap to 0, or park on the last register with the past-end flag set
  always_comb begin
    ptr_inc  = ptr;
    past_inc = past_end;
    if (!past_end) begin
      if (ptr == LAST) begin
        if (WRAP != 0) ptr_inc  = '0;
        else           past_inc = 1'b1;
      end else begin
        ptr_inc = ptr + PTR_W'(1);
      end
    end
  end

  // FSM and datapath state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      past_end  <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      ld        <= 1'b0;
      rw        <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      past_end  <= past_end_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      reg_we    <= we_n;
      reg_waddr <= waddr_n;
      reg_wdata <= wdata_n;
      ld        <= ld_n;
      rw        <= rw_n;
    end
  end

  // next-state logic; START beats STOP beats everything else, ld loads the read shifter
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    ptr_n      = ptr;
    past_end_n = past_end;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    we_n       = 1'b0;
    waddr_n    = reg_waddr;
    wdata_n    = reg_wdata;
    ld_n       = 1'b0;
    rw_n       = rw;
    if (start_c) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_c) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (ld) begin
      shreg_n  = rd_byte;
      sda_oe_n = ~rd_byte[7];
    end else begin
      case (state)
        ADDR, SUB, WDATA: begin
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = 4'd8;
              if (state == ADDR) begin
                if (byte_in[7:1] == I2C_ADDR) begin
                  state_n = ADDR_ACK;
                  rw_n    = byte_in[0];
                end else begin
                  state_n = WAIT_STOP;
                end
              end else if (state == SUB) begin
                if (32'(byte_in) >= NUM_REGS) begin
                  state_n = WAIT_STOP;
                end else begin
                  state_n    = SUB_ACK;
                  ptr_n      = byte_in[PTR_W-1:0];
                  past_end_n = 1'b0;
                end
              end else if (past_end) begin
                state_n = WAIT_STOP;
              end else begin
                state_n    = WDATA_ACK;
                we_n       = 1'b1;
                waddr_n    = ptr;
                wdata_n    = byte_in;
                ptr_n      = ptr_inc;
                past_end_n = past_inc;
              end
            end
          end
        end
        ADDR_ACK, SUB_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n  = 1'b1;
              bit_cnt_n = 4'd9;
              if (state == ADDR_ACK) busy_n = 1'b1;
            end else begin
              bit_cnt_n = '0;
              if (state == ADDR_ACK && rw) begin
                state_n = RDATA;
                ld_n    = 1'b1;
              end else begin
                state_n  = WDATA;
                sda_oe_n = 1'b0;
                if (state == ADDR_ACK) state_n = SUB;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n   = RACK;
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
            end else if (bit_cnt != 4'd0) begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            shreg_n[0] = sda_f;
            bit_cnt_n  = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            bit_cnt_n = '0;
            if (!shreg[0]) begin
              state_n    = RDATA;
              ptr_n      = ptr_inc;
              past_end_n = past_inc;
              ld_n       = 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
